// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N_REQ producers.
// Optional statistics counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_overflow,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    output logic                        fifo_wr_en,
    output logic                        busy,
`ifdef FIFO_ARB_STATS_EN
    output logic                        arb_err,
    output logic [N_REQ*CNT_W-1:0]      gnt_cnt,
    output logic [CNT_W-1:0]            stall_cnt
`else
    output logic                        arb_err
`endif
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic                    wr_en_q, wr_en_d;
    logic                    err_q, err_d;

    logic                    any_req;
    logic [IDXW-1:0]         sel_idx;
    logic                    can_wr;
    logic                    grant_v;

    // A write registered this cycle lands next edge, so almostfull blocks it.
    assign can_wr  = !fifo_full && !(fifo_almostfull && wr_en_q);
    assign grant_v = rst_n && any_req && can_wr;

    // Rotating priority search starting at rr_ptr; the nearest requester wins.
    always_comb begin
        any_req = 1'b0;
        sel_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr_q) + k) % N_REQ;
            if (req[j]) begin
                any_req = 1'b1;
                sel_idx = IDXW'(j);
            end
        end
    end

    // Grant pulse is combinational; held low while reset is asserted.
    always_comb begin
        gnt = '0;
        if (grant_v) begin
            gnt = N_REQ'(1) << sel_idx;
        end
    end

    // Next-state, write-port and pointer update.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        wr_en_d  = 1'b0;
        err_d    = err_q | fifo_overflow;
        if (grant_v) begin
            wr_en_d = 1'b1;
            data_d  = req_data[sel_idx*FIFO_WIDTH +: FIFO_WIDTH];
            if (int'(sel_idx) == N_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = sel_idx + 1'b1;
            end
        end
        unique case (state_q)
            IDLE, GRANT, STALL: begin
                if (!any_req) begin
                    state_d = IDLE;
                end else if (can_wr) begin
                    state_d = GRANT;
                end else begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and write-port registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            err_q    <= err_d;
        end
    end

    assign fifo_data_in = data_q;
    assign fifo_wr_en   = wr_en_q;
    assign busy         = (state_q != IDLE);
    assign arb_err      = err_q;

`ifdef FIFO_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] gnt_cnt_q [N_REQ];
    logic [CNT_W-1:0] gnt_cnt_d [N_REQ];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating per-requester grant counters and stall-cycle counter.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt_cnt_d[i] = gnt_cnt_q[i];
            if (gnt[i] && gnt_cnt_q[i] != CNT_MAX) begin
                gnt_cnt_d[i] = gnt_cnt_q[i] + 1'b1;
            end
        end
        stall_cnt_d = stall_cnt_q;
        if (state_q == STALL && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                gnt_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                gnt_cnt_q[i] <= gnt_cnt_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Flatten per-requester counters onto the output bus.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt_cnt[i*CNT_W +: CNT_W] = gnt_cnt_q[i];
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Counter width only matters when statistics are built in.
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: vector table plus reset/fill sequences.
// The fill sequences use a small depth-8 FIFO occupancy model.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_almostfull;
    logic        fifo_overflow;
    logic [15:0] fifo_data_in;
    logic        fifo_wr_en;
    logic        busy;
    logic        arb_err;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] gnt_cnt;
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .N_REQ(4),
        .FIFO_WIDTH(16),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .fifo_full(fifo_full),
        .fifo_almostfull(fifo_almostfull),
        .fifo_overflow(fifo_overflow),
        .fifo_data_in(fifo_data_in),
        .fifo_wr_en(fifo_wr_en),
        .busy(busy),
`ifdef FIFO_ARB_STATS_EN
        .arb_err(arb_err),
        .gnt_cnt(gnt_cnt),
        .stall_cnt(stall_cnt)
`else
        .arb_err(arb_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic        af;
        logic        ovf;
        logic [3:0]  gnt;
        logic        wr;
        logic [15:0] data;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic f, input logic a,
                       input logic o, input logic [3:0] g, input logic w,
                       input logic [15:0] d, input logic b, input logic e);
        vec_t v;
        v.req = r; v.full = f; v.af = a; v.ovf = o;
        v.gnt = g; v.wr = w; v.data = d; v.busy = b; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v, input int i);
        req             = v.req;
        fifo_full       = v.full;
        fifo_almostfull = v.af;
        fifo_overflow   = v.ovf;
        @(negedge clk);
        chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(v.gnt));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d wr_en", i), 32'(fifo_wr_en), 32'(v.wr));
        chk($sformatf("v%0d data", i), 32'(fifo_data_in), 32'(v.data));
        chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.busy));
        chk($sformatf("v%0d err", i), 32'(arb_err), 32'(v.err));
    endtask

    // depth-8 FIFO model state for the fill/unblock sequences
    int          cnt;
    int          nwr;
    int          ngnt;
    logic [15:0] word;
    logic [15:0] mem [16];
    logic        ovf_next;
    logic        ovf_seen;

    task automatic run_fifo(input int ncyc, input int rd_cyc);
        logic        granted;
        logic        wr_now;
        logic [15:0] d;
        for (int c = 0; c < ncyc; c++) begin
            if (c == rd_cyc && cnt > 0) cnt--;
            fifo_full       = (cnt == 8);
            fifo_almostfull = (cnt == 7);
            fifo_overflow   = ovf_next;
            req             = 4'b0100;
            req_data[32 +: 16] = word;
            @(negedge clk);
            granted = gnt[2];
            wr_now  = fifo_wr_en;
            d       = fifo_data_in;
            if (granted) ngnt++;
            @(posedge clk);
            #1;
            ovf_next = wr_now && (cnt == 8);
            if (ovf_next) ovf_seen = 1'b1;
            if (wr_now && cnt < 8) begin
                if (nwr < 16) mem[nwr] = d;
                nwr++;
                cnt++;
            end
            if (granted) word++;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        req             = '0;
        fifo_full       = 1'b0;
        fifo_almostfull = 1'b0;
        fifo_overflow   = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'hA000 + 16'(i);

        // rotation with all requesters active
        for (int k = 0; k < 8; k++)
            add(4'hF, 0, 0, 0, 4'(1 << (k % 4)), 1, 16'hA000 + 16'(k % 4), 1, 0);
        add(4'h0, 0, 0, 0, 4'h0, 0, 16'hA003, 0, 0);
        // skip and rr_ptr movement
        add(4'h1, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0);
        add(4'h5, 0, 0, 0, 4'h4, 1, 16'hA002, 1, 0);
        add(4'h1, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0);
        // stall then drop before grant
        add(4'h1, 1, 0, 0, 4'h0, 0, 16'hA000, 1, 0);
        add(4'h0, 1, 0, 0, 4'h0, 0, 16'hA000, 0, 0);
        // almostfull with a write in flight
        add(4'h2, 0, 0, 0, 4'h2, 1, 16'hA001, 1, 0);
        add(4'h4, 0, 1, 0, 4'h0, 0, 16'hA001, 1, 0);
        add(4'h4, 0, 1, 0, 4'h4, 1, 16'hA002, 1, 0);
        add(4'h4, 1, 0, 0, 4'h0, 0, 16'hA002, 1, 0);
        add(4'h0, 0, 0, 0, 4'h0, 0, 16'hA002, 0, 0);
        // wrap from rr_ptr=3
        add(4'h9, 0, 0, 0, 4'h8, 1, 16'hA003, 1, 0);
        add(4'h9, 0, 0, 0, 4'h1, 1, 16'hA000, 1, 0);
        add(4'h0, 0, 0, 0, 4'h0, 0, 16'hA000, 0, 0);
        // sticky overflow error
        add(4'h0, 0, 0, 1, 4'h0, 0, 16'hA000, 0, 1);
        add(4'h0, 0, 0, 0, 4'h0, 0, 16'hA000, 0, 1);

        @(posedge clk);
        #1;
        chk("rst gnt", 32'(gnt), 0);
        chk("rst wr_en", 32'(fifo_wr_en), 0);
        chk("rst busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
`ifdef FIFO_ARB_STATS_EN
            if (i == 7)
                for (int r = 0; r < 4; r++)
                    chk($sformatf("gnt_cnt%0d", r),
                        32'(gnt_cnt[r*16 +: 16]), 2);
`endif
        end

        // asynchronous reset in the middle of a burst
        req = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid rst gnt", 32'(gnt), 0);
        chk("mid rst wr_en", 32'(fifo_wr_en), 0);
        chk("mid rst data", 32'(fifo_data_in), 0);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst err", 32'(arb_err), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post rst gnt", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        chk("post rst data", 32'(fifo_data_in), 32'hA000);
        req = 4'h0;
        @(posedge clk);
        #1;

        // fill a depth-8 FIFO from requester 2
        cnt = 0; nwr = 0; ngnt = 0; word = 16'h0001;
        ovf_next = 1'b0; ovf_seen = 1'b0;
        run_fifo(12, -1);
        chk("fill writes", 32'(nwr), 8);
        chk("fill grants", 32'(ngnt), 8);
        chk("fill first", 32'(mem[0]), 32'h0001);
        chk("fill last", 32'(mem[7]), 32'h0008);
        chk("fill busy", 32'(busy), 1);
        chk("fill gnt", 32'(gnt), 0);
        chk("fill ovf", 32'(ovf_seen), 0);
        chk("fill err", 32'(arb_err), 0);
`ifdef FIFO_ARB_STATS_EN
        chk("stall_cnt nz", 32'(stall_cnt != 0), 1);
`endif

        // one read frees one slot
        ngnt = 0;
        run_fifo(6, 0);
        chk("unblk grants", 32'(ngnt), 1);
        chk("unblk writes", 32'(nwr), 9);
        chk("unblk data", 32'(mem[8]), 32'h0009);
        chk("unblk busy", 32'(busy), 1);
        chk("unblk ovf", 32'(ovf_seen), 0);
        chk("unblk err", 32'(arb_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
